// File: rtl/pong_pkg.sv
// Shared types and widths for the pong game sequencer: state encoding,
// score/delay widths and a saturating score increment.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int DELAY_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  // Scores stop at the winning value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_game_fsm_tick_delay.sv
// Loadable down-counter stepped by timing_tick; done is a one-cycle strobe on
// the tick that takes the count from 1 to 0. A tick during load is not counted.
module tick_delay
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_val,
  input  logic               tick,
  output logic               done
);

  logic [DELAY_W-1:0] count_q;
  logic [DELAY_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - DELAY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = !load && tick && (count_q == DELAY_W'(1));

endmodule

// File: rtl/pong_game_fsm.sv
// Pong game sequencer: serves, scores and ends the game around the ball engine.
// Optional PONG_AUTO_RESTART_EN lets GAME_OVER time out back to IDLE.
module pong_game_fsm
  import pong_pkg::*;
#(
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_DELAY   = 60,
  parameter int RESTART_DELAY = 180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_en,
  output logic               ball_recentre,
  output logic               serve_right,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner_left,
  output logic [2:0]         state_o
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  game_state_t        state_q, state_d;
  logic               start_q;
  logic               ball_en_q, ball_en_d;
  logic               recentre_q, recentre_d;
  logic               serve_right_q, serve_right_d;
  logic [SCORE_W-1:0] score_left_q, score_left_d;
  logic [SCORE_W-1:0] score_right_q, score_right_d;
  logic               game_over_q, game_over_d;
  logic               winner_left_q, winner_left_d;
  logic               load_q, load_d;
  logic [DELAY_W-1:0] load_val;
  logic               delay_done;
  logic               start_edge;

  assign start_edge = start && !start_q;

  // The counter loads during the first cycle in the new state, so a tick
  // arriving on the entry cycle is swallowed by the load.
  assign load_val = (state_q == GAME_OVER) ? DELAY_W'(RESTART_DELAY)
                                           : DELAY_W'(SERVE_DELAY);

  tick_delay u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (load_q),
    .load_val (load_val),
    .tick     (timing_tick),
    .done     (delay_done)
  );

  always_comb begin
    state_d       = state_q;
    recentre_d    = 1'b0;
    serve_right_d = serve_right_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_left_d = winner_left_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d       = SERVE;
          score_left_d  = '0;
          score_right_d = '0;
          recentre_d    = 1'b1;
          serve_right_d = 1'b1;
          winner_left_d = 1'b0;
        end
      end
      SERVE: begin
        if (delay_done) state_d = PLAY;
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          state_d = POINT;
        end else if (miss_left) begin
          score_right_d = sat_inc(score_right_q, WIN_VAL);
          serve_right_d = 1'b0;
          state_d       = POINT;
        end else if (miss_right) begin
          score_left_d  = sat_inc(score_left_q, WIN_VAL);
          serve_right_d = 1'b1;
          state_d       = POINT;
        end
      end
      POINT: begin
        if ((score_left_q == WIN_VAL) || (score_right_q == WIN_VAL)) begin
          state_d       = GAME_OVER;
          winner_left_d = (score_left_q == WIN_VAL);
        end else begin
          state_d    = SERVE;
          recentre_d = 1'b1;
        end
      end
      GAME_OVER: begin
`ifdef PONG_AUTO_RESTART_EN
        if (start_edge || delay_done) begin
`else
        if (start_edge) begin
`endif
          state_d       = IDLE;
          winner_left_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    ball_en_d   = (state_d == PLAY);
    game_over_d = (state_d == GAME_OVER);
    load_d      = (state_d != state_q) && ((state_d == SERVE) || (state_d == GAME_OVER));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      ball_en_q     <= 1'b0;
      recentre_q    <= 1'b0;
      serve_right_q <= 1'b1;
      score_left_q  <= '0;
      score_right_q <= '0;
      game_over_q   <= 1'b0;
      winner_left_q <= 1'b0;
      load_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      ball_en_q     <= ball_en_d;
      recentre_q    <= recentre_d;
      serve_right_q <= serve_right_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      game_over_q   <= game_over_d;
      winner_left_q <= winner_left_d;
      load_q        <= load_d;
    end
  end

  assign ball_en       = ball_en_q;
  assign ball_recentre = recentre_q;
  assign serve_right   = serve_right_q;
  assign score_left    = score_left_q;
  assign score_right   = score_right_q;
  assign game_over     = game_over_q;
  assign winner_left   = winner_left_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Scoreboard bench for pong_game_fsm: stimulus queues expected output snapshots
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_pong_game_fsm;
  import pong_pkg::*;

  localparam int WIN = 2;
  localparam int SD  = 3;
  localparam int RD  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       timing_tick = 1'b0;
  logic       start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_en, ball_recentre, serve_right, game_over, winner_left;
  logic [3:0] score_left, score_right;
  logic [2:0] state_o;

  pong_game_fsm #(.WIN_SCORE(WIN), .SERVE_DELAY(SD), .RESTART_DELAY(RD)) dut (
    .clk           (clk),
    .rst           (rst),
    .timing_tick   (timing_tick),
    .start         (start),
    .miss_left     (miss_left),
    .miss_right    (miss_right),
    .ball_en       (ball_en),
    .ball_recentre (ball_recentre),
    .serve_right   (serve_right),
    .score_left    (score_left),
    .score_right   (score_right),
    .game_over     (game_over),
    .winner_left   (winner_left),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {state, ball_en, recentre, serve_right, score_left, score_right, game_over, winner_left}
  function automatic logic [15:0] pack(logic [2:0] st, logic en, logic rc, logic dir,
                                       logic [3:0] sl, logic [3:0] sr, logic go, logic wl);
    return {st, en, rc, dir, sl, sr, go, wl};
  endfunction

  task automatic expect_at(string name, int d, logic [2:0] st, logic en, logic rc, logic dir,
                           logic [3:0] sl, logic [3:0] sr, logic go, logic wl);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = name;
    e.vec  = pack(st, en, rc, dir, sl, sr, go, wl);
    sb_q.push_back(e);
  endtask

  exp_t        mon_e;
  logic [15:0] mon_act;
  always @(negedge clk) begin
    mon_act = pack(state_o, ball_en, ball_recentre, serve_right,
                   score_left, score_right, game_over, winner_left);
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.vec) begin
        n_bad++;
        $display("FAIL %s cyc=%0d (due %0d) got=%h want=%h",
                 mon_e.name, cyc, mon_e.cyc, mon_act, mon_e.vec);
      end else begin
        $display("ok   %s cyc=%0d vec=%h", mon_e.name, cyc, mon_act);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called on the first cycle SERVE is visible; returns with PLAY active.
  task automatic do_serve(logic [3:0] sl, logic [3:0] sr, logic dir);
    start = 1'b0;
    timing_tick = 1'b1;
    step(1);
    timing_tick = 1'b0;
    miss_left = 1'b1;
    miss_right = 1'b1;
    start = 1'b1;
    expect_at("serve_ignore", 1, SERVE, 0, 0, dir, sl, sr, 0, 0);
    step(1);
    miss_left = 1'b0;
    miss_right = 1'b0;
    start = 1'b0;
    for (int i = 0; i < SD; i++) begin
      timing_tick = 1'b1;
      if (i == SD - 1) begin
        expect_at("serve_hold", 0, SERVE, 0, 0, dir, sl, sr, 0, 0);
        expect_at("play_entry", 1, PLAY, 1, 0, dir, sl, sr, 0, 0);
      end
      step(1);
      timing_tick = 1'b0;
      step(1);
    end
  endtask

  task automatic do_miss(logic ml, logic mr, logic [3:0] sl, logic [3:0] sr,
                         logic dir, logic over);
    miss_left = ml;
    miss_right = mr;
    expect_at("point", 1, POINT, 0, 0, dir, sl, sr, 0, 0);
    if (over) expect_at("game_over", 2, GAME_OVER, 0, 0, dir, sl, sr, 1, 1);
    else      expect_at("recentre", 2, SERVE, 0, 1, dir, sl, sr, 0, 0);
    step(1);
    miss_left = 1'b0;
    miss_right = 1'b0;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expired before end of stimulus", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    expect_at("reset", 0, IDLE, 0, 0, 1, 0, 0, 0, 0);
    step(1);
    rst = 1'b1;
    step(1);

    start = 1'b1;
    expect_at("start_serve", 1, SERVE, 0, 1, 1, 0, 0, 0, 0);
    step(1);
    do_serve(0, 0, 1);

    start = 1'b1;
    expect_at("play_ignore_start", 1, PLAY, 1, 0, 1, 0, 0, 0, 0);
    step(1);
    start = 1'b0;
    step(1);

    do_miss(0, 1, 1, 0, 1, 0);
    do_serve(1, 0, 1);
    do_miss(1, 0, 1, 1, 0, 0);
    do_serve(1, 1, 0);
    do_miss(1, 1, 1, 1, 0, 0);
    do_serve(1, 1, 0);

    start = 1'b1;
    step(1);
    do_miss(0, 1, 2, 1, 1, 1);

    miss_left = 1'b1;
    miss_right = 1'b1;
    expect_at("go_ignore_miss", 1, GAME_OVER, 0, 0, 1, 2, 1, 1, 1);
    step(1);
    miss_left = 1'b0;
    miss_right = 1'b0;
    for (int i = 0; i < RD; i++) begin
      timing_tick = 1'b1;
      if (i == RD - 1) begin
`ifdef PONG_AUTO_RESTART_EN
        expect_at("auto_restart", 1, IDLE, 0, 0, 1, 2, 1, 0, 0);
`else
        expect_at("go_hold", 1, GAME_OVER, 0, 0, 1, 2, 1, 1, 1);
`endif
      end
      step(1);
      timing_tick = 1'b0;
      step(1);
    end

`ifndef PONG_AUTO_RESTART_EN
    start = 1'b0;
    step(1);
    start = 1'b1;
    expect_at("go_exit", 1, IDLE, 0, 0, 1, 2, 1, 0, 0);
    step(1);
`endif
    start = 1'b0;
    step(1);
    expect_at("idle_hold", 0, IDLE, 0, 0, 1, 2, 1, 0, 0);
    start = 1'b1;
    expect_at("new_game", 1, SERVE, 0, 1, 1, 0, 0, 0, 0);
    step(1);
    do_serve(0, 0, 1);

    rst = 1'b0;
    expect_at("async_reset", 0, IDLE, 0, 0, 1, 0, 0, 0, 0);
    step(1);
    rst = 1'b1;
    step(2);
    expect_at("post_reset_idle", 0, IDLE, 0, 0, 1, 0, 0, 0, 0);
    step(2);

    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
